accum_unit: RTL and testbench



---
 rtl/accum_pkg.sv | 12 +
 rtl/Parallel_Adder.sv | 23 ++
 rtl/accum_unit.sv | 85 ++++++++
 tb/tb_accum_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and widths for the accumulator unit.
package accum_pkg;

    localparam int unsigned DATA_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SUM    = 2'b01,
        S_REPORT = 2'b10
    } state_t;

endpackage

// File: rtl/Parallel_Adder.sv
// 4-bit ripple-carry adder: S = A + B + C_in, with carry-out.
module Parallel_Adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_in,
    output logic [3:0] S,
    output logic       C_out
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        S        = '0;
        carry[0] = C_in;
        for (int i = 0; i < 4; i++) begin
            S[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        C_out = carry[4];
    end

endmodule

// File: rtl/accum_unit.sv
// Registered accumulator around Parallel_Adder with valid/ready in and out
// and a saturating count of carry-out events.
module accum_unit
    import accum_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] acc_out,
    output logic              carry_flag,
    output logic [CNT_W-1:0]  ovf_count
);

    localparam logic [CNT_W-1:0] OvfMax = '1;

    state_t            state_q;
    logic [DATA_W-1:0] op_q;
    logic [DATA_W-1:0] acc_q;
    logic              carry_q;
    logic [CNT_W-1:0]  ovf_q;

    logic [DATA_W-1:0] sum;
    logic              sum_carry;

    Parallel_Adder u_adder (
        .A     (acc_q),
        .B     (op_q),
        .C_in  (1'b0),
        .S     (sum),
        .C_out (sum_carry)
    );

    // clear takes priority over every handshake; op_q is left alone on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= '0;
        end else if (clear) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_data;
                        state_q <= S_SUM;
                    end
                end
                S_SUM: begin
                    acc_q   <= sum;
                    carry_q <= sum_carry;
                    if (sum_carry && (ovf_q != OvfMax)) begin
                        ovf_q <= ovf_q + 1'b1;
                    end
                    state_q <= S_REPORT;
                end
                S_REPORT: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE) && !clear && rst_n;
    assign out_valid  = (state_q == S_REPORT) && !clear;
    assign acc_out    = acc_q;
    assign carry_flag = carry_q;
    assign ovf_count  = ovf_q;

endmodule

// File: tb/tb_accum_unit.sv
// Directed scoreboard bench for accum_unit: one instance with CNT_W=4, one with CNT_W=2.
module tb_accum_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clear_s     [2];
    logic       in_valid_s  [2];
    logic       in_ready_s  [2];
    logic       out_valid_s [2];
    logic       out_ready_s [2];
    logic       carry_s     [2];
    logic [3:0] in_data_s   [2];
    logic [3:0] acc_s       [2];
    logic [3:0] ovf_a;
    logic [1:0] ovf_b;

    accum_unit #(.CNT_W(4)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear_s[0]),
        .in_valid   (in_valid_s[0]),
        .in_ready   (in_ready_s[0]),
        .in_data    (in_data_s[0]),
        .out_valid  (out_valid_s[0]),
        .out_ready  (out_ready_s[0]),
        .acc_out    (acc_s[0]),
        .carry_flag (carry_s[0]),
        .ovf_count  (ovf_a)
    );

    accum_unit #(.CNT_W(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear_s[1]),
        .in_valid   (in_valid_s[1]),
        .in_ready   (in_ready_s[1]),
        .in_data    (in_data_s[1]),
        .out_valid  (out_valid_s[1]),
        .out_ready  (out_ready_s[1]),
        .acc_out    (acc_s[1]),
        .carry_flag (carry_s[1]),
        .ovf_count  (ovf_b)
    );

    typedef struct {
        int acc;
        int carry;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_acc [2];
    int   m_ovf [2];
    int   m_max [2];

    function automatic logic [31:0] ovf_of(input int sel);
        return (sel == 0) ? {28'd0, ovf_a} : {30'd0, ovf_b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: 4-bit wrap, carry out, saturating counter.
    task automatic model_add(input int sel, input int d);
        int   s;
        exp_t e;
        s = m_acc[sel] + d;
        m_acc[sel] = s & 15;
        if (s > 15 && m_ovf[sel] < m_max[sel]) m_ovf[sel]++;
        e.acc   = m_acc[sel];
        e.carry = (s > 15) ? 1 : 0;
        e.ovf   = m_ovf[sel];
        sb.push_back(e);
    endtask

    // mode 0: plain output handshake; 1: stall 5 cycles with in_valid held;
    // 2: clear together with out_ready in S_REPORT.
    task automatic add_op(input int sel, input logic [3:0] d, input int mode);
        int   n;
        exp_t e;
        n = 0;
        while (in_ready_s[sel] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready_s[sel]}, 1);
        in_valid_s[sel] = 1'b1;
        in_data_s[sel]  = d;
        @(posedge clk);
        #1;
        in_valid_s[sel] = 1'b0;
        in_data_s[sel]  = 4'd0;
        model_add(sel, int'(d));
        @(negedge clk);
        check("sum_out_valid", {31'd0, out_valid_s[sel]}, 0);
        check("sum_in_ready", {31'd0, in_ready_s[sel]}, 0);
        @(negedge clk);
        check("out_valid_latency", {31'd0, out_valid_s[sel]}, 1);
        e = sb.pop_front();
        check("acc_out", {28'd0, acc_s[sel]}, e.acc);
        check("carry_flag", {31'd0, carry_s[sel]}, e.carry);
        check("ovf_count", ovf_of(sel), e.ovf);
        if (mode == 1) begin
            in_valid_s[sel] = 1'b1;
            in_data_s[sel]  = 4'b0101;
            repeat (5) begin
                @(negedge clk);
                check("stall_acc", {28'd0, acc_s[sel]}, e.acc);
                check("stall_out_valid", {31'd0, out_valid_s[sel]}, 1);
                check("stall_in_ready", {31'd0, in_ready_s[sel]}, 0);
            end
        end
        if (mode == 2) begin
            clear_s[sel]     = 1'b1;
            out_ready_s[sel] = 1'b1;
            #1;
            check("clear_out_valid_now", {31'd0, out_valid_s[sel]}, 0);
            check("clear_in_ready_now", {31'd0, in_ready_s[sel]}, 0);
            @(posedge clk);
            #1;
            clear_s[sel]     = 1'b0;
            out_ready_s[sel] = 1'b0;
            m_acc[sel] = 0;
            m_ovf[sel] = 0;
            @(negedge clk);
            check("clear_acc", {28'd0, acc_s[sel]}, 0);
            check("clear_carry", {31'd0, carry_s[sel]}, 0);
            check("clear_ovf", ovf_of(sel), 0);
            check("clear_out_valid", {31'd0, out_valid_s[sel]}, 0);
            check("clear_in_ready", {31'd0, in_ready_s[sel]}, 1);
        end else begin
            out_ready_s[sel] = 1'b1;
            @(posedge clk);
            #1;
            out_ready_s[sel] = 1'b0;
            in_valid_s[sel]  = 1'b0;
            in_data_s[sel]   = 4'd0;
            @(negedge clk);
            check("post_hs_in_ready", {31'd0, in_ready_s[sel]}, 1);
            check("post_hs_out_valid", {31'd0, out_valid_s[sel]}, 0);
            check("post_hs_acc", {28'd0, acc_s[sel]}, e.acc);
            if (mode == 1) begin
                @(negedge clk);
                check("stall_no_consume", {31'd0, in_ready_s[sel]}, 1);
            end
        end
    endtask

    initial begin
        m_max[0] = 15;
        m_max[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_acc[i]       = 0;
            m_ovf[i]       = 0;
            clear_s[i]     = 1'b0;
            in_valid_s[i]  = 1'b0;
            out_ready_s[i] = 1'b0;
            in_data_s[i]   = 4'd0;
        end
        rst_n = 1'b0;
        #2;
        check("rst_in_ready", {31'd0, in_ready_s[0]}, 0);
        check("rst_out_valid", {31'd0, out_valid_s[0]}, 0);
        check("rst_acc", {28'd0, acc_s[0]}, 0);
        check("rst_carry", {31'd0, carry_s[0]}, 0);
        check("rst_ovf", ovf_of(0), 0);
        check("rst_ovf_b", ovf_of(1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        add_op(0, 4'b1011, 0);
        add_op(0, 4'b1101, 0);
        add_op(0, 4'b1111, 0);
        add_op(0, 4'b0000, 0);
        add_op(0, 4'b0001, 1);
        add_op(0, 4'b1001, 2);
        add_op(0, 4'b0101, 0);

        // Reset pulse while an operand sits in S_SUM.
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 4'b0110;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        in_data_s[0]  = 4'd0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_acc", {28'd0, acc_s[0]}, 0);
        check("async_rst_carry", {31'd0, carry_s[0]}, 0);
        check("async_rst_ovf", ovf_of(0), 0);
        check("async_rst_in_ready", {31'd0, in_ready_s[0]}, 0);
        check("async_rst_out_valid", {31'd0, out_valid_s[0]}, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        m_acc[0] = 0;
        m_ovf[0] = 0;
        add_op(0, 4'b0011, 0);

        // Narrow counter: preload 1111, then every further 1111 carries out.
        add_op(1, 4'b1111, 0);
        repeat (5) add_op(1, 4'b1111, 0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
